// File: rtl/agc_sequencer.sv
// agc_sequencer: round-robin closed-loop gain control stepping three PWM gain words toward a shared histogram target
// Ports: clk50 / clk50_reset (synchronous, active-high); enable[2:0] per-channel loop enable (bit0 = ch1);
//        target shared magnitude target; manual_pwm_ch1..3 gain words used while a channel is disabled;
//        hist_ch1..3 magnitude fractions; pwm_ch1..3 gain words to the pwm blocks;
//        locked[2:0] last evaluation fell in the deadband; cur_ch engine owner (3 = idle);
//        update_count completed evaluations (wraps).
module agc_sequencer #(
    parameter logic [15:0] SETTLE   = 16'd50000,
    parameter logic [9:0]  STEP     = 10'd4,
    parameter logic [7:0]  DEADBAND = 8'd8
) (
    input  logic       clk50,
    input  logic       clk50_reset,
    input  logic [2:0] enable,
    input  logic [7:0] target,
    input  logic [9:0] manual_pwm_ch1,
    input  logic [9:0] manual_pwm_ch2,
    input  logic [9:0] manual_pwm_ch3,
    input  logic [7:0] hist_ch1,
    input  logic [7:0] hist_ch2,
    input  logic [7:0] hist_ch3,
    output logic [9:0] pwm_ch1,
    output logic [9:0] pwm_ch2,
    output logic [9:0] pwm_ch3,
    output logic [2:0] locked,
    output logic [1:0] cur_ch,
    output logic [7:0] update_count
);
    typedef enum logic [2:0] {IDLE, SELECT, SETTLING, SAMPLE, UPDATE} state_t;
    state_t state, state_nx;
    logic [2:0][9:0] pwm, manual;
    logic [2:0][7:0] hist;
    logic [15:0] cnt;
    logic [7:0] h;
    logic aborted, found, upd, lock_new;
    logic [1:0] start, c1, c2, pick;
    logic [8:0] hi, lo;
    logic [10:0] up_sum;
    logic [9:0] pwm_cur, pwm_up, pwm_dn, pwm_new;

    assign manual = {manual_pwm_ch3, manual_pwm_ch2, manual_pwm_ch1};
    assign hist = {hist_ch3, hist_ch2, hist_ch1};
    assign {pwm_ch3, pwm_ch2, pwm_ch1} = pwm;

    // Search starts just after the last owner; idle (3) and channel 2 both wrap to channel 0,
    // and the last candidate is the previous owner itself so a lone channel is reselected.
    assign start = (cur_ch >= 2'd2) ? 2'd0 : cur_ch + 2'd1;
    assign c1 = (start == 2'd2) ? 2'd0 : start + 2'd1;
    assign c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    assign pick = enable[start] ? start : enable[c1] ? c1 : c2;
    assign found = |enable;

    // 9-bit bounds so target + DEADBAND cannot wrap; lo clamps at zero.
    assign hi = {1'b0, target} + {1'b0, DEADBAND};
    assign lo = (target >= DEADBAND) ? {1'b0, target - DEADBAND} : 9'd0;
    assign pwm_cur = pwm[cur_ch];
    assign up_sum = {1'b0, pwm_cur} + {1'b0, STEP};
    assign pwm_up = up_sum[10] ? 10'd1023 : up_sum[9:0];
    assign pwm_dn = (pwm_cur < STEP) ? 10'd0 : pwm_cur - STEP;
    assign lock_new = ({1'b0, h} <= hi) && ({1'b0, h} >= lo);
    assign pwm_new = ({1'b0, h} > hi) ? pwm_dn : ({1'b0, h} < lo) ? pwm_up : pwm_cur;
    // A channel disabled at any point from SAMPLE onward forfeits this evaluation.
    assign upd = (state == UPDATE) && !aborted && enable[cur_ch];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = found ? SELECT : IDLE;
            SELECT:   state_nx = found ? SETTLING : IDLE;
            SETTLING: state_nx = !enable[cur_ch] ? SELECT : (cnt == SETTLE - 16'd1) ? SAMPLE : SETTLING;
            SAMPLE:   state_nx = UPDATE;
            UPDATE:   state_nx = SELECT;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (clk50_reset) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk50) begin
        if (clk50_reset) begin
            pwm <= {3{10'd512}};
            locked <= '0;
            cur_ch <= 2'd3;
            update_count <= '0;
            cnt <= '0;
            h <= '0;
            aborted <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!enable[i]) begin
                    pwm[i] <= manual[i];
                    locked[i] <= 1'b0;
                end else if (upd && cur_ch == 2'(i)) begin
                    pwm[i] <= pwm_new;
                    locked[i] <= lock_new;
                end
            end
            if (state == SELECT) begin
                cur_ch <= found ? pick : 2'd3;
                cnt <= '0;
            end
            if (state == SETTLING) cnt <= cnt + 16'd1;
            if (state == SAMPLE) begin
                h <= hist[cur_ch];
                aborted <= !enable[cur_ch];
            end
            if (upd) update_count <= update_count + 8'd1;
        end
    end
endmodule
